// File: rtl/fir_tap_delay_line_pkg.sv
// Shared types, limits and helpers for the FIR tapped delay line.
package fir_pkg;

  localparam int TAPS_MIN = 2;
  localparam int TAPS_MAX = 64;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    PRIMED  = 2'd2
  } fill_state_e;

  function automatic int product_width(input int data_width);
    return 2 * data_width;
  endfunction

  // LSB index of stage i within the flattened tap bus.
  function automatic int tap_slice(input int i, input int pw);
    return i * pw;
  endfunction

endpackage

// File: rtl/fir_tap_delay_line_if.sv
// Delay-line bus: sample/control in, parallel taps and fill status out.
// sym_o exists only when FIR_DLY_SYM_EN is defined.
interface fir_dly_if #(
  parameter int PW    = 32,
  parameter int TAPS  = 8,
  parameter int CNT_W = $clog2(TAPS + 1)
);
  logic signed [PW-1:0]          din;
  logic                          ld;
  logic                          flush;
  logic [TAPS*PW-1:0]            taps_o;
  logic                          primed;
  logic [CNT_W-1:0]              fill_cnt;
  logic                          out_valid;
`ifdef FIR_DLY_SYM_EN
  logic [(TAPS/2)*(PW+1)-1:0]    sym_o;
`endif

  modport master (
    output din, ld, flush,
`ifdef FIR_DLY_SYM_EN
    input  sym_o,
`endif
    input  taps_o, primed, fill_cnt, out_valid
  );

  modport slave (
    input  din, ld, flush,
`ifdef FIR_DLY_SYM_EN
    output sym_o,
`endif
    output taps_o, primed, fill_cnt, out_valid
  );
endinterface

// File: rtl/fir_tap_delay_line_stage.sv
// One delay-line stage: async reset, synchronous clear, load enable.
module fir_dly_stage #(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic signed [WIDTH-1:0] d_i,
  output logic signed [WIDTH-1:0] q_o
);

  logic signed [WIDTH-1:0] data_q;

  // Clear takes priority so a flush discards a simultaneous load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (clr_i) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/fir_tap_delay_line.sv
// Signed tapped delay line with fill tracking for the FIR datapath.
// Optional registered symmetric pre-adders enabled by FIR_DLY_SYM_EN.
module fir_tap_delay_line
  import fir_pkg::*;
#(
  parameter int DATAWIDTH     = 16,
  parameter int PRODUCT_WIDTH = product_width(DATAWIDTH),
  parameter int TAPS          = 8,
  parameter int CNT_W         = $clog2(TAPS + 1)
) (
  input logic      clk,
  input logic      rst,
  fir_dly_if.slave bus
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAPS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TAPS - 1);

  if (TAPS < TAPS_MIN || TAPS > TAPS_MAX) begin : g_bad_taps
    $error("fir_tap_delay_line: TAPS=%0d outside %0d..%0d", TAPS, TAPS_MIN, TAPS_MAX);
  end
  if (PRODUCT_WIDTH < DATAWIDTH) begin : g_bad_width
    $error("fir_tap_delay_line: PRODUCT_WIDTH=%0d narrower than DATAWIDTH=%0d",
           PRODUCT_WIDTH, DATAWIDTH);
  end

  logic signed [PRODUCT_WIDTH-1:0] stage_q [TAPS];
  logic signed [PRODUCT_WIDTH-1:0] stage_d [TAPS];

  genvar gi;
  for (gi = 0; gi < TAPS; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      assign stage_d[gi] = bus.din;
    end else begin : g_body
      assign stage_d[gi] = stage_q[gi-1];
    end

    fir_dly_stage #(
      .WIDTH (PRODUCT_WIDTH)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .clr_i (bus.flush),
      .en_i  (bus.ld),
      .d_i   (stage_d[gi]),
      .q_o   (stage_q[gi])
    );

    assign bus.taps_o[tap_slice(gi, PRODUCT_WIDTH) +: PRODUCT_WIDTH] = stage_q[gi];
  end

  fill_state_e      state_q;
  logic [CNT_W-1:0] fill_cnt_q;
  logic             primed_q;
  logic             out_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      fill_cnt_q  <= '0;
      primed_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (bus.flush) begin
      state_q     <= EMPTY;
      fill_cnt_q  <= '0;
      primed_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (bus.ld) begin
        case (state_q)
          EMPTY: begin
            fill_cnt_q <= CNT_W'(1);
            state_q    <= FILLING;
          end
          FILLING: begin
            if (fill_cnt_q == LAST_CNT) begin
              fill_cnt_q  <= FULL_CNT;
              state_q     <= PRIMED;
              primed_q    <= 1'b1;
              out_valid_q <= 1'b1;
            end else begin
              fill_cnt_q <= fill_cnt_q + CNT_W'(1);
            end
          end
          PRIMED: begin
            out_valid_q <= 1'b1;
          end
          default: begin
            state_q    <= EMPTY;
            fill_cnt_q <= '0;
            primed_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.fill_cnt  = fill_cnt_q;
  assign bus.primed    = primed_q;
  assign bus.out_valid = out_valid_q;

`ifdef FIR_DLY_SYM_EN
  localparam int SW = PRODUCT_WIDTH + 1;

  // Sums come from next-state stage values so they line up with taps_o.
  for (gi = 0; gi < TAPS / 2; gi++) begin : g_sym
    logic signed [SW-1:0] sum_d;
    logic signed [SW-1:0] sum_q;

    assign sum_d = {stage_d[gi][PRODUCT_WIDTH-1], stage_d[gi]}
                 + {stage_d[TAPS-1-gi][PRODUCT_WIDTH-1], stage_d[TAPS-1-gi]};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sum_q <= '0;
      end else if (bus.flush) begin
        sum_q <= '0;
      end else if (bus.ld) begin
        sum_q <= sum_d;
      end
    end

    assign bus.sym_o[gi*SW +: SW] = sum_q;
  end
`endif

endmodule

// File: tb/tb_fir_tap_delay_line.sv
// Randomized self-checking bench for fir_tap_delay_line against a sample-history model.
module tb_fir_tap_delay_line;

  parameter int DW   = 16;
  parameter int TAPS = 8;
  localparam int PW    = 2 * DW;
  localparam int CNT_W = $clog2(TAPS + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  fir_dly_if #(.PW(PW), .TAPS(TAPS), .CNT_W(CNT_W)) bus ();

  fir_tap_delay_line #(
    .DATAWIDTH (DW),
    .TAPS      (TAPS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_txn    = 0;

  // Most recent sample first; length is the number of loaded stages.
  logic [PW-1:0] hist [$];
  logic          exp_ov = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] model_tap(input int i);
    return (i < hist.size()) ? hist[i] : '0;
  endfunction

  task automatic check_all(input string ctx);
    for (int i = 0; i < TAPS; i++) begin
      check_eq($sformatf("%s tap%0d", ctx, i), 64'(bus.taps_o[i*PW +: PW]), 64'(model_tap(i)));
    end
    check_eq($sformatf("%s fill_cnt", ctx), 64'(bus.fill_cnt), 64'(hist.size()));
    check_eq($sformatf("%s primed", ctx), 64'(bus.primed), 64'(hist.size() == TAPS));
    check_eq($sformatf("%s out_valid", ctx), 64'(bus.out_valid), 64'(exp_ov));
`ifdef FIR_DLY_SYM_EN
    for (int k = 0; k < TAPS / 2; k++) begin
      longint a;
      longint b;
      logic [63:0] mask;
      a    = longint'($signed(model_tap(k)));
      b    = longint'($signed(model_tap(TAPS - 1 - k)));
      mask = (64'd1 << (PW + 1)) - 64'd1;
      check_eq($sformatf("%s sym%0d", ctx, k),
               64'(bus.sym_o[k*(PW+1) +: (PW+1)]), 64'(a + b) & mask);
    end
`endif
  endtask

  task automatic step(input string ctx, input logic [PW-1:0] d, input logic l, input logic f);
    bus.din   = d;
    bus.ld    = l;
    bus.flush = f;
    @(posedge clk);
    #1;
    if (f) begin
      hist.delete();
      exp_ov = 1'b0;
    end else if (l) begin
      hist.push_front(d);
      if (hist.size() > TAPS) void'(hist.pop_back());
      exp_ov = (hist.size() == TAPS);
    end else begin
      exp_ov = 1'b0;
    end
    n_txn++;
    $display("txn %0d %s ld=%0b flush=%0b din=%08h fill=%0d primed=%0b out_valid=%0b",
             n_txn, ctx, l, f, d, bus.fill_cnt, bus.primed, bus.out_valid);
    check_all(ctx);
  endtask

  initial begin
    bus.din   = '0;
    bus.ld    = 1'b0;
    bus.flush = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    for (int i = 1; i <= TAPS; i++) step("fill", PW'(i), 1'b1, 1'b0);
    repeat (3) step("hold", PW'(32'hDEAD_BEEF), 1'b0, 1'b0);
    step("steady", PW'(TAPS + 1), 1'b1, 1'b0);
    step("steady2", PW'(TAPS + 2), 1'b1, 1'b0);

    step("flush_ld", PW'(32'h7FFF_0000), 1'b1, 1'b1);
    step("after_flush", PW'(32'h0000_0055), 1'b1, 1'b0);
    step("flush", '0, 1'b0, 1'b1);

    for (int i = 0; i < TAPS + 3; i++) begin
      step("extreme", (i % 2 == 0) ? PW'(32'h8000_0000) : PW'(32'h7FFF_FFFF), 1'b1, 1'b0);
    end
    for (int i = 0; i < TAPS; i++) step("all_min", PW'(32'h8000_0000), 1'b1, 1'b0);
    step("one_max", PW'(32'h7FFF_FFFF), 1'b1, 1'b0);

    for (int i = 0; i < 120; i++) begin
      step("rand", PW'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end

    step("flush2", '0, 1'b0, 1'b1);
    for (int i = 0; i < TAPS + 2; i++) step("refill", PW'($urandom), 1'b1, 1'b0);

    // Asynchronous reset between clock edges must clear outputs immediately.
    bus.ld = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    hist.delete();
    exp_ov = 1'b0;
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_held");
    rst = 1'b0;
    step("post_rst", PW'(32'h1234_5678), 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fir_tap_delay_line.md
Name: fir_tap_delay_line

Overview:
Parametrised, load-enabled, signed tapped delay line for the N-tap FIR datapath. It replaces the per-stage single delay registers with one shift chain of TAPS stages, all exposed in parallel. It tracks fill state so downstream MAC/adder logic knows when every tap holds a real sample. It sits between the multiplier array output (or input sample register) and the accumulate tree.

Parameters:
DATAWIDTH, 16, input sample width in bits
PRODUCT_WIDTH, 2*DATAWIDTH, width of each stored stage (signed)
TAPS, 8, number of delay stages; legal range 2..64
CNT_W, $clog2(TAPS+1), width of fill counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
din  in  PRODUCT_WIDTH  signed sample entering stage 0
ld  in  1  shift enable: din->stage0, stage[i]->stage[i+1]
flush  in  1  synchronous clear of all stages and fill state
taps_o  out  TAPS*PRODUCT_WIDTH  flattened stages; stage i at bits [i*PW +: PW]
primed  out  1  high when all TAPS stages hold loaded samples
fill_cnt  out  CNT_W  number of valid stages, 0..TAPS, saturating
out_valid  out  1  one-cycle pulse the cycle after a ld that leaves the line primed
sym_o  out  (TAPS/2)*(PRODUCT_WIDTH+1)  symmetric pre-add sums (only with FIR_DLY_SYM_EN)

Behaviour:
- Reset (rst=1, async): every stage=0, fill_cnt=0, primed=0, out_valid=0, state=EMPTY.
- Shift: on a clk edge with ld=1 and flush=0, stage0<=din and stage[i]<=stage[i-1]; new values are visible on taps_o next cycle (1-cycle latency). With ld=0, all stages hold.
- Flush: flush=1 at a clk edge clears all stages to 0, fill_cnt to 0, primed to 0, out_valid to 0, and goes to EMPTY. Flush wins over a simultaneous ld, so that din is discarded.
- FSM, states EMPTY, FILLING, PRIMED:
  - EMPTY: on ld, fill_cnt<=1 and move to FILLING. If TAPS were 1 it would go to PRIMED, but TAPS>=2 is enforced.
  - FILLING: each ld increments fill_cnt. The ld that makes fill_cnt==TAPS moves to PRIMED.
  - PRIMED: fill_cnt stays at TAPS (saturates, no wrap). ld keeps shifting. Only flush or rst leaves this state.
- primed = (state==PRIMED), registered.
- out_valid is registered. It is 1 in the cycle after any accepted ld whose resulting state is PRIMED, including the ld that completes filling; otherwise it is 0. Back-to-back ld in PRIMED gives continuous out_valid.
- All stages are signed two's complement. There is no width change through the chain.
- Elaboration: TAPS<2 or TAPS>64 raises an elaboration error via a generate-time check.

Optional Feature:
Macro: FIR_DLY_SYM_EN
- Defined: sym_o[k] = sign-extended stage[k] + stage[TAPS-1-k] for k=0..TAPS/2-1, width PRODUCT_WIDTH+1, so it cannot overflow.
  - The sums are registered and update on the same edge as the shift, from the next-state stage values. sym_o is therefore aligned with taps_o.
  - Cleared by rst and flush.
  - For odd TAPS, the centre stage is not summed; it is taken from taps_o.
- Undefined: the sym_o port is absent and no adders are built.

Decomposition:
- Package fir_pkg: PRODUCT_WIDTH derivation, the fill-state enum (EMPTY/FILLING/PRIMED), the TAPS range limits, and the tap_slice index helper function.
- One sub-module, fir_dly_stage: a single PRODUCT_WIDTH register with async reset, sync clear and load enable. It is instantiated TAPS times in a generate loop.
- The FSM, counter and optional pre-adders stay in the top.

Test Plan:
- Reset during PRIMED: assert rst mid-stream -> all taps_o, fill_cnt, primed and out_valid are 0 immediately, without waiting for a clock edge.
- Fill, TAPS=8: ld samples 1..8 -> fill_cnt steps 1..8; primed rises after the 8th; out_valid pulses on the cycle after the 8th; taps_o stage0=8 and stage7=1.
- Hold and steady state: ld gapped (ld=0 for 3 cycles) -> taps unchanged. Then 9th sample -> stage7=2, fill_cnt stays 8, out_valid=1.
- Flush with simultaneous ld=1, din=0x7FFF0000 -> all stages 0, state EMPTY, din not captured. The next ld gives fill_cnt=1.
- Signed extremes: load -2^31 and 2^31-1 alternately -> values propagate bit-exact. With FIR_DLY_SYM_EN, the pair sum is -1 at 33 bits; two stages of -2^31 sum to -2^32 with no overflow.
- TAPS=3 build, odd and minimal: fills in 3 lds. With FIR_DLY_SYM_EN, sym_o[0]=stage0+stage2; the centre stage is excluded.
